// File: rtl/sc_bs_accum_pkg.sv
// sc_bs_accum_pkg: shared widths, saturation limits and FSM encoding for the bitstream accumulator
package sc_bs_accum_pkg;
  localparam int BS_WIDTH = 32;
  localparam int POP_WIDTH = 6;
  localparam int ACC_WIDTH = 16;
  localparam int CNT_WIDTH = 12;
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;
endpackage

// File: rtl/sc_bs_accum_if.sv
// sc_bs_accum_if: input word stream and frame result handshake
interface sc_bs_accum_if;
  import sc_bs_accum_pkg::*;
  logic in_valid;
  logic in_ready;
  logic [BS_WIDTH-1:0] in_bs;
  logic in_last;
  logic out_valid;
  logic out_ready;
  logic [ACC_WIDTH-1:0] out_sum;
  logic [CNT_WIDTH-1:0] out_cnt;
  logic out_ovf;
  modport master (output in_valid, in_bs, in_last, out_ready, input in_ready, out_valid, out_sum, out_cnt, out_ovf);
  modport slave (input in_valid, in_bs, in_last, out_ready, output in_ready, out_valid, out_sum, out_cnt, out_ovf);
endinterface

// File: rtl/sc_bs_accum_popcount.sv
// sc_bs_accum_popcount: combinational ones count of one bitstream word
module sc_bs_accum_popcount
  import sc_bs_accum_pkg::*;
(
  input  logic [BS_WIDTH-1:0]  bs,
  output logic [POP_WIDTH-1:0] pop
);
  always_comb begin
    pop = '0;
    for (int i = 0; i < BS_WIDTH; i++) pop = pop + POP_WIDTH'(bs[i]);
  end
endmodule

// File: rtl/sc_bs_accum.sv
// sc_bs_accum: popcount stochastic bitstream words and accumulate them per frame with saturation
module sc_bs_accum
  import sc_bs_accum_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  sc_bs_accum_if.slave  bus
);
  logic p1_valid, p1_last, ovf_r, stall, advance, accept, retire, done, sat;
  logic [POP_WIDTH-1:0] pop, p1_pop;
  logic [ACC_WIDTH-1:0] acc, next_sum;
  logic [CNT_WIDTH-1:0] wcnt, next_cnt;
  logic [ACC_WIDTH:0] sum_w;
  logic [CNT_WIDTH:0] cnt_w;
  state_t state;

  sc_bs_accum_popcount u_pop (.bs(bus.in_bs), .pop(pop));

  assign stall = p1_valid && p1_last && bus.out_valid && !bus.out_ready;
  assign advance = !stall;
  assign bus.in_ready = !stall;
  assign accept = bus.in_valid && !stall;
  assign retire = p1_valid && advance;
  assign done = retire && p1_last;
  // an IDLE state means no partial frame, so the running totals start from zero
  assign sum_w = (state == IDLE ? '0 : {1'b0, acc}) + (ACC_WIDTH+1)'(p1_pop);
  assign cnt_w = (state == IDLE ? '0 : {1'b0, wcnt}) + (CNT_WIDTH+1)'(1);
  assign next_sum = sum_w[ACC_WIDTH] ? ACC_MAX : sum_w[ACC_WIDTH-1:0];
  assign next_cnt = cnt_w[CNT_WIDTH] ? CNT_MAX : cnt_w[CNT_WIDTH-1:0];
  assign sat = sum_w[ACC_WIDTH] | cnt_w[CNT_WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_valid <= 1'b0;
      p1_last <= 1'b0;
      p1_pop <= '0;
      acc <= '0;
      wcnt <= '0;
      ovf_r <= 1'b0;
      state <= IDLE;
      bus.out_valid <= 1'b0;
      bus.out_sum <= '0;
      bus.out_cnt <= '0;
      bus.out_ovf <= 1'b0;
    end else begin
      if (advance) begin
        p1_valid <= accept;
        if (accept) begin
          p1_pop <= pop;
          p1_last <= bus.in_last;
        end
      end
      if (retire) begin
        state <= p1_last ? IDLE : ACCUM;
        acc <= p1_last ? '0 : next_sum;
        wcnt <= p1_last ? '0 : next_cnt;
        ovf_r <= !p1_last && (ovf_r | sat);
      end
      if (done) begin
        bus.out_valid <= 1'b1;
        bus.out_sum <= next_sum;
        bus.out_cnt <= next_cnt;
        bus.out_ovf <= ovf_r | sat;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sc_bs_accum.sv
// tb_sc_bs_accum: vector table, directed corner sequences and random traffic against a frame-level model
module tb_sc_bs_accum;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  sc_bs_accum_if bus();
  sc_bs_accum dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [15:0] sum;
    logic [11:0] cnt;
    logic        ovf;
  } res_t;

  typedef struct {
    logic [31:0] bs;
    logic        last;
    logic        has;
    logic [15:0] sum;
    logic [11:0] cnt;
    logic        ovf;
  } vec_t;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ready_low = 0;
  res_t exp_q[$];
  res_t obs_q[$];
  int obs_cyc[$];
  longint cur_sum = 0;
  longint cur_cnt = 0;
  logic hold = 1'b0;
  res_t held;
  vec_t vecs[7];
  logic took;

  function automatic void chk(string name, logic [63:0] got, logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endfunction

  function automatic logic [28:0] pk(res_t r);
    return {r.sum, r.cnt, r.ovf};
  endfunction

  function automatic res_t cur_out();
    res_t r;
    r.sum = bus.out_sum;
    r.cnt = bus.out_cnt;
    r.ovf = bus.out_ovf;
    return r;
  endfunction

  // reference: a frame's result is the true popcount total and word count, clipped to the field widths
  task automatic model_accept(input logic [31:0] bs, input logic l);
    res_t r;
    cur_sum += longint'($countones(bs));
    cur_cnt++;
    if (l) begin
      r.sum = (cur_sum > 65535) ? 16'hFFFF : 16'(cur_sum);
      r.cnt = (cur_cnt > 4095) ? 12'hFFF : 12'(cur_cnt);
      r.ovf = (cur_sum > 65535) || (cur_cnt > 4095);
      exp_q.push_back(r);
      cur_sum = 0;
      cur_cnt = 0;
    end
  endtask

  task automatic step(input logic v, input logic [31:0] bs, input logic l, input logic ordy, output logic acc);
    res_t o;
    res_t e;
    @(negedge clk);
    bus.in_valid = v;
    bus.in_bs = bs;
    bus.in_last = l;
    bus.out_ready = ordy;
    #1;
    cyc++;
    o = cur_out();
    if (hold) begin
      chk("hold_valid", 64'(bus.out_valid), 64'd1);
      chk("hold_fields", 64'(pk(o)), 64'(pk(held)));
    end
    if (!bus.in_ready) ready_low++;
    acc = v && bus.in_ready;
    if (acc) model_accept(bs, l);
    hold = bus.out_valid && !ordy;
    held = o;
    if (bus.out_valid && ordy) begin
      obs_q.push_back(o);
      obs_cyc.push_back(cyc);
      if (exp_q.size() == 0) chk("unexpected_result", 64'(pk(o)), 64'h1FFFFFFF);
      else begin
        e = exp_q.pop_front();
        chk("result", 64'(pk(o)), 64'(pk(e)));
      end
    end
  endtask

  task automatic send(input logic [31:0] bs, input logic l, input logic ordy);
    logic a;
    for (int n = 0; n < 50; n++) begin
      step(1'b1, bs, l, ordy, a);
      if (a) return;
    end
    chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(input int n, input logic ordy);
    logic a;
    repeat (n) step(1'b0, 32'h0, 1'b0, ordy, a);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_bs = '0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_sum", 64'(bus.out_sum), 64'd0);
    chk("rst_out_cnt", 64'(bus.out_cnt), 64'd0);
    chk("rst_out_ovf", 64'(bus.out_ovf), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // single full word: result visible two cycles after acceptance
    send(32'hFFFFFFFF, 1'b1, 1'b1);
    idle(1, 1'b1);
    chk("lat_t1_valid", 64'(bus.out_valid), 64'd0);
    idle(1, 1'b1);
    chk("lat_t2_valid", 64'(bus.out_valid), 64'd1);
    chk("lat_t2_fields", 64'(pk(cur_out())), 64'(pk('{16'd32, 12'd1, 1'b0})));
    idle(2, 1'b1);

    vecs[0] = '{32'h0000FFFF, 1'b0, 1'b0, 16'd0, 12'd0, 1'b0};
    vecs[1] = '{32'hAAAAAAAA, 1'b0, 1'b0, 16'd0, 12'd0, 1'b0};
    vecs[2] = '{32'h00000001, 1'b0, 1'b0, 16'd0, 12'd0, 1'b0};
    vecs[3] = '{32'h80000000, 1'b1, 1'b1, 16'd34, 12'd4, 1'b0};
    vecs[4] = '{32'h00000001, 1'b1, 1'b1, 16'd1, 12'd1, 1'b0};
    vecs[5] = '{32'h00000003, 1'b1, 1'b1, 16'd2, 12'd1, 1'b0};
    vecs[6] = '{32'h00000007, 1'b1, 1'b1, 16'd3, 12'd1, 1'b0};
    obs_q.delete();
    obs_cyc.delete();
    ready_low = 0;
    foreach (vecs[i]) send(vecs[i].bs, vecs[i].last, 1'b1);
    idle(3, 1'b1);
    chk("tbl_ready_low", 64'(ready_low), 64'd0);
    begin
      int k = 0;
      foreach (vecs[i]) if (vecs[i].has) begin
        if (k < obs_q.size())
          chk("tbl_result", 64'(pk(obs_q[k])), 64'(pk('{vecs[i].sum, vecs[i].cnt, vecs[i].ovf})));
        else chk("tbl_missing", 64'(k), 64'(obs_q.size()));
        k++;
      end
      chk("tbl_count", 64'(obs_q.size()), 64'(k));
    end
    if (obs_q.size() == 4) chk("b2b_consecutive", 64'(obs_cyc[3] - obs_cyc[1]), 64'd2);

    // backpressure: frame B's last word waits behind unconsumed frame A
    obs_q.delete();
    send(32'hFFFFFFFF, 1'b1, 1'b0);
    send(32'h0000000F, 1'b1, 1'b0);
    idle(1, 1'b0);
    chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
    chk("bp_a_held", 64'(pk(cur_out())), 64'(pk('{16'd32, 12'd1, 1'b0})));
    idle(1, 1'b0);
    chk("bp_in_ready2", 64'(bus.in_ready), 64'd0);
    idle(1, 1'b1);
    idle(1, 1'b1);
    chk("bp_b_valid", 64'(bus.out_valid), 64'd1);
    chk("bp_b_fields", 64'(pk(cur_out())), 64'(pk('{16'd4, 12'd1, 1'b0})));
    idle(2, 1'b1);

    // overflow then a clean frame
    obs_q.delete();
    for (int i = 0; i < 2048; i++) send(32'hFFFFFFFF, i == 2047, 1'b1);
    send(32'h00000003, 1'b1, 1'b1);
    idle(4, 1'b1);
    chk("ovf_count", 64'(obs_q.size()), 64'd2);
    if (obs_q.size() == 2) begin
      chk("ovf_frame", 64'(pk(obs_q[0])), 64'(pk('{16'hFFFF, 12'd2048, 1'b1})));
      chk("ovf_next", 64'(pk(obs_q[1])), 64'(pk('{16'd2, 12'd1, 1'b0})));
    end

    // asynchronous reset in the middle of a frame
    obs_q.delete();
    repeat (3) send(32'hFFFFFFFF, 1'b0, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_outputs", 64'({bus.out_valid, pk(cur_out())}), 64'd0);
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    cur_sum = 0;
    cur_cnt = 0;
    exp_q.delete();
    hold = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(4, 1'b1);
    chk("mid_rst_no_result", 64'(obs_q.size()), 64'd0);
    send(32'h00000001, 1'b1, 1'b1);
    idle(3, 1'b1);
    chk("mid_rst_next_count", 64'(obs_q.size()), 64'd1);
    if (obs_q.size() == 1) chk("mid_rst_next", 64'(pk(obs_q[0])), 64'(pk('{16'd1, 12'd1, 1'b0})));

    // random traffic with random backpressure
    for (int i = 0; i < 600; i++) begin
      logic [31:0] w;
      int m;
      m = int'($urandom_range(0, 3));
      w = (m == 0) ? 32'hFFFFFFFF : (m == 1) ? 32'h0 : $urandom;
      step($urandom_range(0, 3) != 0, w, $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0, took);
    end
    send($urandom, 1'b1, 1'b1);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) idle(1, 1'b1);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    idle(2, 1'b1);
    chk("drain_idle_valid", 64'(bus.out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
